// File: rtl/fixedpoint_multiplier.sv
// rtl/fixedpoint_multiplier.sv - sequential sign-magnitude shift-add fixed-point multiplier
// Optional round-half-up normalisation when FXP_MUL_ROUND_EN is defined; truncates otherwise.
module fixedpoint_multiplier #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] product_out,
    output logic             overflow,
    output logic             error,
    output logic             finished,
    output logic             busy
);
    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(M) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2*M-1:0]   r_mcand;
    logic [M-1:0]     r_mplier;
    logic [2*M-1:0]   r_acc;
    logic             r_sign;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_product;
    logic             r_overflow;
    logic             r_finished;

    logic [2*M-FRAC-M-1:0] w_hi;
    logic [M:0]            w_rnd;
    logic                  w_ovf;
    logic [M-1:0]          w_mag;
    logic                  w_sign_out;

    assign product_out = r_product;
    assign overflow    = r_overflow;
    assign error       = r_overflow;
    assign finished    = r_finished;
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_next = S_MUL;
            S_MUL:   if (r_cnt == '0) w_next = S_NORM;
            S_NORM:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bits above the integer field, or a rounding carry, mean the result does not fit.
    assign w_hi = r_acc[2*M-1:FRAC+M];
`ifdef FXP_MUL_ROUND_EN
    assign w_rnd = {1'b0, r_acc[FRAC+M-1:FRAC]} + {{M{1'b0}}, r_acc[FRAC-1]};
`else
    assign w_rnd = {1'b0, r_acc[FRAC+M-1:FRAC]};
`endif
    assign w_ovf      = (|w_hi) | w_rnd[M];
    assign w_mag      = w_ovf ? {M{1'b1}} : w_rnd[M-1:0];
    assign w_sign_out = r_sign & (|w_mag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_sign     <= 1'b0;
            r_cnt      <= '0;
            r_product  <= '0;
            r_overflow <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_mcand    <= {{M{1'b0}}, multiplicand[M-1:0]};
                        r_mplier   <= multiplier[M-1:0];
                        r_sign     <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
                        r_acc      <= '0;
                        r_cnt      <= CW'(M - 1);
                        r_finished <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                S_MUL: begin
                    // Multiplicand moves left as the multiplier moves right, so bit i adds A<<i.
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_NORM: begin
                    r_product  <= {w_sign_out, w_mag};
                    r_overflow <= w_ovf;
                    r_finished <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixedpoint_multiplier.sv
// tb/tb_fixedpoint_multiplier.sv - scoreboard bench for fixedpoint_multiplier
module tb_fixedpoint_multiplier;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [15:0] product_out;
    logic        overflow;
    logic        error;
    logic        finished;
    logic        busy;

    fixedpoint_multiplier #(.WIDTH(16), .FRAC(10)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .product_out(product_out), .overflow(overflow), .error(error),
        .finished(finished), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] prod;
        logic        ovf;
        int          fin_cyc;
    } exp_t;
    exp_t sb[$];
    logic fin_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && finished && !fin_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_finish", 32'd1, 32'd0);
            end else begin
                chk("product", {16'd0, product_out}, {16'd0, sb[0].prod});
                chk("overflow", {31'd0, overflow}, {31'd0, sb[0].ovf});
                chk("error", {31'd0, error}, {31'd0, sb[0].ovf});
                chk("latency", cyc, sb[0].fin_cyc);
                sb.pop_front();
            end
        end
        fin_prev <= finished;
    end

    task automatic wait_fin();
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (finished) got = 1'b1;
        end
        if (!got) chk("finish_timeout", 32'd0, 32'd1);
    endtask

    // Accept happens on the posedge after this negedge; finish is 16 edges later.
    task automatic start(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] p, input logic o);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        enable       = 1'b1;
        sb.push_back('{p, o, cyc + 17});
        @(negedge clk);
        enable = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] p, input logic o);
        start(a, b, p, o);
        wait_fin();
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        multiplicand = 16'h0000;
        multiplier   = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_product", {16'd0, product_out}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_finished", {31'd0, finished}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        issue(16'h0600, 16'h0800, 16'h0C00, 1'b0);
        issue(16'h8600, 16'h0800, 16'h8C00, 1'b0);
        issue(16'h8600, 16'h8800, 16'h0C00, 1'b0);
        issue(16'h4000, 16'h0800, 16'h7FFF, 1'b1);
        issue(16'h7FFF, 16'h0400, 16'h7FFF, 1'b0);
        issue(16'h0000, 16'h7FFF, 16'h0000, 1'b0);
        issue(16'h8000, 16'h0400, 16'h0000, 1'b0);
`ifdef FXP_MUL_ROUND_EN
        issue(16'h8001, 16'h0200, 16'h8001, 1'b0);
        issue(16'h0003, 16'h0200, 16'h0002, 1'b0);
`else
        issue(16'h8001, 16'h0200, 16'h0000, 1'b0);
        issue(16'h0003, 16'h0200, 16'h0001, 1'b0);
`endif

        // Second enable pulse mid-operation with new operands must be ignored.
        start(16'h0600, 16'h0800, 16'h0C00, 1'b0);
        repeat (4) @(negedge clk);
        multiplicand = 16'h4000;
        multiplier   = 16'h0800;
        enable       = 1'b1;
        chk("busy_during_pulse", {31'd0, busy}, 32'd1);
        @(negedge clk);
        enable = 1'b0;
        wait_fin();

        // Reset in the eighth MUL cycle aborts with no result.
        @(negedge clk);
        multiplicand = 16'h0600;
        multiplier   = 16'h0800;
        enable       = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_product", {16'd0, product_out}, 32'd0);
        chk("abort_overflow", {31'd0, overflow}, 32'd0);
        chk("abort_finished", {31'd0, finished}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);

        // Reset and enable together: the start is dropped.
        enable = 1'b1;
        @(negedge clk);
        chk("rst_en_busy", {31'd0, busy}, 32'd0);
        rst    = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("rst_en_idle", {31'd0, busy}, 32'd0);

        issue(16'h0600, 16'h8800, 16'h8C00, 1'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
